// File: rtl/conv_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conv_pkg                                                   |
// | Description : Shared FSM states, CSR map and display-mode codes for the  |
// |               conv frame sequencer.                                      |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package conv_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_SOP = 3'd1,
    ST_STREAM   = 3'd2,
    ST_FLUSH    = 3'd3,
    ST_DRAIN    = 3'd4
  } conv_state_t;

  // CSR word addresses
  localparam logic [1:0] c_addr_ctrl      = 2'd0;
  localparam logic [1:0] c_addr_mode      = 2'd1;
  localparam logic [1:0] c_addr_status    = 2'd2;
  localparam logic [1:0] c_addr_frame_cnt = 2'd3;

  // CTRL bit indices
  localparam int c_ctrl_enable = 0;
  localparam int c_ctrl_irq_en = 1;

  // STATUS bit indices
  localparam int c_st_busy       = 0;
  localparam int c_st_frame_done = 1;
  localparam int c_st_sop_err    = 2;
  localparam int c_st_len_err    = 3;

  // Kernel select codes understood by the filter; any other value is MEAN
  localparam logic [6:0] c_mode_original  = 7'd0;
  localparam logic [6:0] c_mode_gauss1    = 7'd1;
  localparam logic [6:0] c_mode_gauss2    = 7'd2;
  localparam logic [6:0] c_mode_sobel_x   = 7'd4;
  localparam logic [6:0] c_mode_sobel_y   = 7'd8;
  localparam logic [6:0] c_mode_prewitt_x = 7'd16;
  localparam logic [6:0] c_mode_prewitt_y = 7'd32;

endpackage
`default_nettype wire

// File: rtl/conv_csr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conv_csr                                                   |
// | Description : Avalon-MM register file: CTRL, MODE, sticky W1C STATUS,    |
// |               frame counter, registered read data and level IRQ.         |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module conv_csr
  import conv_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic        busy,
  input  logic        set_frame_done,
  input  logic        set_sop_err,
  input  logic        set_len_err,
  output logic        enable,
  output logic [6:0]  mode_pending,
  output logic        irq
);

  logic        r_enable;
  logic        r_irq_en;
  logic [6:0]  r_mode_pending;
  logic        r_frame_done;
  logic        r_sop_err;
  logic        r_len_err;
  logic [15:0] r_frame_cnt;
  logic [31:0] r_readdata;

  logic        w_wr_ctrl;
  logic        w_wr_mode;
  logic        w_wr_status;
  logic [31:0] w_rd_mux;
  logic        w_unused_wdata;

  assign w_wr_ctrl      = avs_write && (avs_address == c_addr_ctrl);
  assign w_wr_mode      = avs_write && (avs_address == c_addr_mode);
  assign w_wr_status    = avs_write && (avs_address == c_addr_status);
  assign w_unused_wdata = ^avs_writedata[31:7];

  // Host-writable control and pending-mode registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_enable       <= 1'b0;
      r_irq_en       <= 1'b0;
      r_mode_pending <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_enable <= avs_writedata[c_ctrl_enable];
        r_irq_en <= avs_writedata[c_ctrl_irq_en];
      end
      if (w_wr_mode) begin
        r_mode_pending <= avs_writedata[6:0];
      end
    end
  end

  // Sticky status flags; a hardware set in the same cycle beats a W1C clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_done <= 1'b0;
      r_sop_err    <= 1'b0;
      r_len_err    <= 1'b0;
    end else begin
      if (set_frame_done) begin
        r_frame_done <= 1'b1;
      end else if (w_wr_status && avs_writedata[c_st_frame_done]) begin
        r_frame_done <= 1'b0;
      end
      if (set_sop_err) begin
        r_sop_err <= 1'b1;
      end else if (w_wr_status && avs_writedata[c_st_sop_err]) begin
        r_sop_err <= 1'b0;
      end
      if (set_len_err) begin
        r_len_err <= 1'b1;
      end else if (w_wr_status && avs_writedata[c_st_len_err]) begin
        r_len_err <= 1'b0;
      end
    end
  end

  // Completed-frame counter, free-running wrap at 16 bits
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_frame_cnt <= '0;
    end else if (set_frame_done) begin
      r_frame_cnt <= r_frame_cnt + 16'd1;
    end
  end

  // Read-side register selection
  always_comb begin
    w_rd_mux = '0;
    case (avs_address)
      c_addr_ctrl: begin
        w_rd_mux[c_ctrl_enable] = r_enable;
        w_rd_mux[c_ctrl_irq_en] = r_irq_en;
      end
      c_addr_mode: begin
        w_rd_mux[6:0] = r_mode_pending;
      end
      c_addr_status: begin
        w_rd_mux[c_st_busy]       = busy;
        w_rd_mux[c_st_frame_done] = r_frame_done;
        w_rd_mux[c_st_sop_err]    = r_sop_err;
        w_rd_mux[c_st_len_err]    = r_len_err;
      end
      default: begin
        w_rd_mux[15:0] = r_frame_cnt;
      end
    endcase
  end

  // Registered read data, valid the cycle after the read strobe
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= '0;
    end else if (avs_read) begin
      r_readdata <= w_rd_mux;
    end
  end

  assign avs_readdata = r_readdata;
  assign enable       = r_enable;
  assign mode_pending = r_mode_pending;
  assign irq          = r_irq_en & r_frame_done;

endmodule
`default_nettype wire

// File: rtl/conv_frame_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : conv_frame_ctrl                                            |
// | Description : Frame sequencer in front of the 3x3 conv filter. Forwards  |
// |               exactly WIDTH*HEIGHT pixels per frame, pads short frames,  |
// |               flushes the filter line delay and waits for its EOP.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module conv_frame_ctrl
  import conv_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 640,
  parameter int IMAGE_HEIGHT = 480,
  parameter int FLUSH_LEN    = IMAGE_WIDTH + 9,
  parameter int EOP_TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  avs_address,
  input  logic        avs_write,
  input  logic [31:0] avs_writedata,
  input  logic        avs_read,
  output logic [31:0] avs_readdata,
  input  logic [7:0]  snk_data,
  input  logic        snk_valid,
  input  logic        snk_sop,
  input  logic        snk_eop,
  output logic        snk_ready,
  output logic [7:0]  conv_pxl_in,
  output logic        conv_valid_in,
  input  logic        conv_ready_in,
  output logic [6:0]  conv_display_mode,
  input  logic        conv_eop_out,
  output logic        irq
);

  localparam int c_num_pix   = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam int c_pix_w     = $clog2(c_num_pix + 1);
  localparam int c_flush_max = (c_num_pix > FLUSH_LEN) ? c_num_pix : FLUSH_LEN;
  localparam int c_flush_w   = $clog2(c_flush_max + 1);
  localparam int c_to_w      = $clog2(EOP_TIMEOUT + 1);

  localparam logic [c_pix_w-1:0]   c_num_pix_v = c_pix_w'(c_num_pix);
  localparam logic [c_flush_w-1:0] c_flush_v   = c_flush_w'(FLUSH_LEN);
  localparam logic [c_to_w-1:0]    c_to_last   = c_to_w'(EOP_TIMEOUT - 1);

  conv_state_t          r_state;
  logic [c_pix_w-1:0]   r_pix_cnt;
  logic [c_flush_w-1:0] r_flush_cnt;
  logic                 r_pad_phase;
  logic [c_to_w-1:0]    r_to_cnt;
  logic                 r_eop_seen;
  logic [6:0]           r_active_mode;

  conv_state_t          w_state_nxt;
  logic [c_pix_w-1:0]   w_pix_cnt_nxt;
  logic [c_flush_w-1:0] w_flush_cnt_nxt;
  logic                 w_pad_phase_nxt;
  logic [c_to_w-1:0]    w_to_cnt_nxt;
  logic                 w_eop_seen_nxt;
  logic                 w_enter_wait;
  logic                 w_conv_valid;
  logic [7:0]           w_conv_pxl;
  logic                 w_set_sop_err;
  logic                 w_set_len_err;
  logic                 w_frame_done;
  logic                 w_sink_open;
  logic                 w_accept;
  logic                 w_busy;
  logic                 w_enable;
  logic [6:0]           w_mode_pending;

  // The sink is only open while waiting for or streaming a frame
  assign w_sink_open = (r_state == ST_WAIT_SOP) || (r_state == ST_STREAM);
  assign snk_ready   = w_sink_open & conv_ready_in;
  assign w_accept    = snk_valid & snk_ready;
  assign w_busy      = !((r_state == ST_IDLE) || (r_state == ST_WAIT_SOP));

  // Next-state, counter and filter-side output decode
  always_comb begin
    w_state_nxt     = r_state;
    w_pix_cnt_nxt   = r_pix_cnt;
    w_flush_cnt_nxt = r_flush_cnt;
    w_pad_phase_nxt = r_pad_phase;
    w_to_cnt_nxt    = r_to_cnt;
    w_eop_seen_nxt  = r_eop_seen;
    w_enter_wait    = 1'b0;
    w_conv_valid    = 1'b0;
    w_conv_pxl      = '0;
    w_set_sop_err   = 1'b0;
    w_set_len_err   = 1'b0;
    w_frame_done    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_enable) begin
          w_state_nxt  = ST_WAIT_SOP;
          w_enter_wait = 1'b1;
        end
      end
      ST_WAIT_SOP: begin
        if (w_accept) begin
          if (!snk_sop) begin
            // Beats ahead of the first SOP are discarded
            w_set_sop_err = 1'b1;
          end else begin
            w_conv_valid  = 1'b1;
            w_conv_pxl    = snk_data;
            w_pix_cnt_nxt = c_pix_w'(1);
            if (c_num_pix_v == c_pix_w'(1)) begin
              w_state_nxt     = ST_FLUSH;
              w_flush_cnt_nxt = c_flush_v;
              w_pad_phase_nxt = 1'b0;
            end else begin
              w_state_nxt = ST_STREAM;
            end
          end
        end else if (!w_enable) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_STREAM: begin
        w_conv_valid = w_accept;
        if (w_accept) begin
          w_conv_pxl    = snk_data;
          w_pix_cnt_nxt = r_pix_cnt + c_pix_w'(1);
          if (snk_sop) begin
            w_set_sop_err = 1'b1;
          end
          if (w_pix_cnt_nxt == c_num_pix_v) begin
            w_set_len_err   = !snk_eop;
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = c_flush_v;
            w_pad_phase_nxt = 1'b0;
          end else if (snk_eop) begin
            // Short frame: pad up to a full frame before the flush run
            w_set_len_err   = 1'b1;
            w_state_nxt     = ST_FLUSH;
            w_flush_cnt_nxt = c_flush_w'(c_num_pix_v - w_pix_cnt_nxt);
            w_pad_phase_nxt = 1'b1;
          end
        end
      end
      ST_FLUSH: begin
        if (conv_eop_out) begin
          w_eop_seen_nxt = 1'b1;
        end
        if (conv_ready_in) begin
          w_conv_valid = 1'b1;
          if (r_flush_cnt == c_flush_w'(1)) begin
            if (r_pad_phase) begin
              w_flush_cnt_nxt = c_flush_v;
              w_pad_phase_nxt = 1'b0;
            end else begin
              w_state_nxt  = ST_DRAIN;
              w_to_cnt_nxt = '0;
            end
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - c_flush_w'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (conv_eop_out || r_eop_seen || (r_to_cnt == c_to_last)) begin
          w_set_len_err  = !(conv_eop_out || r_eop_seen);
          w_frame_done   = 1'b1;
          w_eop_seen_nxt = 1'b0;
          if (w_enable) begin
            w_state_nxt  = ST_WAIT_SOP;
            w_enter_wait = 1'b1;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else begin
          w_to_cnt_nxt = r_to_cnt + c_to_w'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State and counter registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_pix_cnt   <= '0;
      r_flush_cnt <= '0;
      r_pad_phase <= 1'b0;
      r_to_cnt    <= '0;
      r_eop_seen  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_pix_cnt   <= w_pix_cnt_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
      r_pad_phase <= w_pad_phase_nxt;
      r_to_cnt    <= w_to_cnt_nxt;
      r_eop_seen  <= w_eop_seen_nxt;
    end
  end

  // Kernel select only changes when a new frame is about to be awaited
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_active_mode <= '0;
    end else if (w_enter_wait) begin
      r_active_mode <= w_mode_pending;
    end
  end

  assign conv_valid_in     = w_conv_valid;
  assign conv_pxl_in       = w_conv_pxl;
  assign conv_display_mode = r_active_mode;

  conv_csr u_csr (
    .clk            (clk),
    .reset_n        (reset_n),
    .avs_address    (avs_address),
    .avs_write      (avs_write),
    .avs_writedata  (avs_writedata),
    .avs_read       (avs_read),
    .avs_readdata   (avs_readdata),
    .busy           (w_busy),
    .set_frame_done (w_frame_done),
    .set_sop_err    (w_set_sop_err),
    .set_len_err    (w_set_len_err),
    .enable         (w_enable),
    .mode_pending   (w_mode_pending),
    .irq            (irq)
  );

endmodule
`default_nettype wire

// File: tb/tb_conv_frame_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// +--------------------------------------------------------------------------+
// | Module      : tb_conv_frame_ctrl                                         |
// | Description : Randomized self-checking bench for conv_frame_ctrl with a  |
// |               frame-level reference model and a model filter.            |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_conv_frame_ctrl;

  localparam int W    = 8;
  localparam int H    = 4;
  localparam int FL   = 17;
  localparam int NPIX = W * H;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  avs_address = '0;
  logic        avs_write = 1'b0;
  logic [31:0] avs_writedata = '0;
  logic        avs_read = 1'b0;
  logic [31:0] avs_readdata;
  logic [7:0]  snk_data = '0;
  logic        snk_valid = 1'b0;
  logic        snk_sop = 1'b0;
  logic        snk_eop = 1'b0;
  logic        snk_ready;
  logic [7:0]  conv_pxl_in;
  logic        conv_valid_in;
  logic        conv_ready_in = 1'b1;
  logic [6:0]  conv_display_mode;
  logic        conv_eop_out = 1'b0;
  logic        irq;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  logic [6:0]  m_pending = '0;
  logic [6:0]  m_active  = '0;
  bit          m_enable  = 1'b0;
  bit          m_irq_en  = 1'b0;
  logic [3:0]  m_status  = '0;
  int          m_frames  = 0;
  logic [14:0] q_exp[$];
  logic [14:0] q_out[$];
  bit          filt_eop_en = 1'b1;
  bit          valid_wo_ready = 1'b0;
  int          src_beats = 0;
  int          f_cnt = 0;
  int          f_cd = 0;

  conv_frame_ctrl #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H),
    .FLUSH_LEN   (FL),
    .EOP_TIMEOUT (255)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .avs_address      (avs_address),
    .avs_write        (avs_write),
    .avs_writedata    (avs_writedata),
    .avs_read         (avs_read),
    .avs_readdata     (avs_readdata),
    .snk_data         (snk_data),
    .snk_valid        (snk_valid),
    .snk_sop          (snk_sop),
    .snk_eop          (snk_eop),
    .snk_ready        (snk_ready),
    .conv_pxl_in      (conv_pxl_in),
    .conv_valid_in    (conv_valid_in),
    .conv_ready_in    (conv_ready_in),
    .conv_display_mode(conv_display_mode),
    .conv_eop_out     (conv_eop_out),
    .irq              (irq)
  );

  always #5 clk = ~clk;

  // Filter backpressure: ready most of the time
  initial forever begin
    @(negedge clk);
    conv_ready_in = ($urandom_range(0, 3) != 0);
  end

  // Model filter plus output monitor: records every beat, raises EOP 3 cycles after the last flush pixel
  initial forever begin
    @(negedge clk);
    conv_eop_out = (f_cd == 1) && filt_eop_en;
    if (f_cd > 0) f_cd--;
    #4;
    if (!reset_n) begin
      f_cnt = 0;
      f_cd  = 0;
      conv_eop_out = 1'b0;
    end else if (conv_valid_in) begin
      if (!conv_ready_in) valid_wo_ready = 1'b1;
      q_out.push_back({conv_display_mode, conv_pxl_in});
      f_cnt++;
      if (f_cnt == NPIX + FL) begin
        f_cnt = 0;
        f_cd  = 3;
      end
    end
  end

  task automatic csr_write(input logic [1:0] a, input logic [31:0] d);
    avs_address = a; avs_writedata = d; avs_write = 1'b1;
    @(negedge clk);
    avs_write = 1'b0;
    case (a)
      2'd0: begin
        if (d[0] && !m_enable) m_active = m_pending;
        m_enable = d[0];
        m_irq_en = d[1];
      end
      2'd1: m_pending = d[6:0];
      2'd2: m_status = m_status & ~{d[3:1], 1'b0};
      default: ;
    endcase
  endtask

  task automatic csr_read(input logic [1:0] a, output logic [31:0] d);
    avs_address = a; avs_read = 1'b1;
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic send_beat(input logic [7:0] d, input bit sop, input bit eop);
    int n = 0;
    bit acc = 1'b0;
    snk_data = d; snk_sop = sop; snk_eop = eop; snk_valid = 1'b1;
    while (!acc && n < 500) begin
      #4;
      acc = snk_ready;
      @(negedge clk);
      n++;
    end
    snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
    if (!acc) begin
      n_checks++;
      $display("FAIL send_beat: beat not accepted within %0d cycles", n);
    end else begin
      src_beats++;
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
  endtask

  // Sends optional pre-SOP garbage then a frame whose EOP sits on pixel eop_at
  task automatic send_frame(input int n_garbage, input int eop_at);
    logic [7:0] d;
    for (int i = 0; i < n_garbage; i++) begin
      send_beat(8'($urandom), 1'b0, 1'b0);
      m_status[2] = 1'b1;
    end
    src_beats = 0;
    for (int p = 1; p <= eop_at; p++) begin
      d = 8'($urandom);
      q_exp.push_back({m_active, d});
      send_beat(d, p == 1, p == eop_at);
    end
    for (int p = eop_at; p < NPIX + FL; p++) q_exp.push_back({m_active, 8'h00});
    if (eop_at != NPIX) m_status[3] = 1'b1;
  endtask

  task automatic finish_frame(input string tag);
    logic [31:0] rd;
    int n = 0;
    int bad = 0;
    m_frames++;
    m_status[1] = 1'b1;
    do begin
      csr_read(2'd3, rd);
      n++;
    end while (rd[15:0] != 16'(m_frames) && n < 400);
    n_checks++;
    if (rd[15:0] !== 16'(m_frames))
      $display("FAIL %s frame_cnt: got %0d expected %0d", tag, rd[15:0], m_frames);
    else n_pass++;
    if (m_enable) m_active = m_pending;
    n_checks++;
    if (q_out.size() != q_exp.size())
      $display("FAIL %s stream_len: got %0d beats expected %0d", tag, q_out.size(), q_exp.size());
    else n_pass++;
    for (int i = 0; i < q_out.size() && i < q_exp.size(); i++)
      if (q_out[i] !== q_exp[i]) bad++;
    n_checks++;
    if (bad != 0)
      $display("FAIL %s stream_data: %0d beats differ (mode,pixel)", tag, bad);
    else n_pass++;
    q_out.delete();
    q_exp.delete();
    csr_read(2'd2, rd);
    n_checks++;
    if (rd !== {28'd0, m_status[3:1], 1'b0})
      $display("FAIL %s status: got %0h expected %0h", tag, rd, {28'd0, m_status[3:1], 1'b0});
    else n_pass++;
    n_checks++;
    if (irq !== (m_irq_en & m_status[1]))
      $display("FAIL %s irq: got %0b expected %0b", tag, irq, m_irq_en & m_status[1]);
    else n_pass++;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    repeat (3) @(negedge clk);
    snk_valid = 1'b1;
    #1;
    n_checks++;
    if ({snk_ready, conv_valid_in, conv_pxl_in, conv_display_mode, avs_readdata, irq} !== 50'd0)
      $display("FAIL reset_outputs: got %0h expected 0",
               {snk_ready, conv_valid_in, conv_pxl_in, conv_display_mode, avs_readdata, irq});
    else n_pass++;
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    n_checks++;
    if (snk_ready !== 1'b0) $display("FAIL idle_ready: got %0b expected 0", snk_ready);
    else n_pass++;
    snk_valid = 1'b0;
    @(negedge clk);
    for (int a = 0; a < 4; a++) begin
      csr_read(2'(a), rd);
      n_checks++;
      if (rd !== 32'd0) $display("FAIL reset_csr%0d: got %0h expected 0", a, rd);
      else n_pass++;
    end
  endtask

  task automatic test_clean_frame();
    csr_write(2'd1, 32'd4);
    csr_write(2'd0, 32'd1);
    send_frame(0, NPIX);
    finish_frame("clean");
    n_checks++;
    if (conv_display_mode !== 7'd4) $display("FAIL clean_mode: got %0d expected 4", conv_display_mode);
    else n_pass++;
  endtask

  task automatic test_irq();
    csr_write(2'd2, 32'hE);
    csr_write(2'd0, 32'd3);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL irq_pre: got %0b expected 0", irq);
    else n_pass++;
    send_frame(0, NPIX);
    finish_frame("irq");
    csr_write(2'd2, 32'h2);
    n_checks++;
    if (irq !== 1'b0) $display("FAIL irq_clear: got %0b expected 0", irq);
    else n_pass++;
    csr_write(2'd0, 32'd1);
  endtask

  task automatic test_mode_switch();
    csr_write(2'd2, 32'hE);
    fork
      send_frame(0, NPIX);
      begin
        for (int k = 0; k < 3000 && src_beats < 9; k++) @(negedge clk);
        csr_write(2'd1, 32'd1);
      end
    join
    finish_frame("mode_a");
    send_frame(0, NPIX);
    finish_frame("mode_b");
    n_checks++;
    if (conv_display_mode !== 7'd1) $display("FAIL mode_b_out: got %0d expected 1", conv_display_mode);
    else n_pass++;
  endtask

  task automatic test_sop_err();
    csr_write(2'd2, 32'hE);
    send_frame(2, NPIX);
    finish_frame("sop_err");
  endtask

  task automatic test_len_err();
    csr_write(2'd2, 32'hE);
    send_frame(0, 20);
    finish_frame("len_err");
  endtask

  task automatic test_reset_flush_timeout();
    logic [31:0] rd;
    int k;
    csr_write(2'd2, 32'hE);
    send_frame(0, NPIX);
    for (k = 0; k < 2000 && q_out.size() < NPIX + 4; k++) @(negedge clk);
    n_checks++;
    if (q_out.size() < NPIX + 4) $display("FAIL flush_reached: got %0d beats expected >= %0d", q_out.size(), NPIX + 4);
    else n_pass++;
    #2;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({snk_ready, conv_valid_in, conv_pxl_in, conv_display_mode, avs_readdata, irq} !== 50'd0)
      $display("FAIL flush_reset_outputs: got %0h expected 0",
               {snk_ready, conv_valid_in, conv_pxl_in, conv_display_mode, avs_readdata, irq});
    else n_pass++;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    q_out.delete(); q_exp.delete();
    m_pending = '0; m_active = '0; m_enable = 1'b0; m_irq_en = 1'b0; m_status = '0; m_frames = 0;
    @(negedge clk);
    csr_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'd0) $display("FAIL reset_frame_cnt: got %0d expected 0", rd);
    else n_pass++;
    filt_eop_en = 1'b0;
    csr_write(2'd0, 32'd1);
    send_frame(0, NPIX);
    for (k = 0; k < 2000 && q_out.size() < NPIX + FL; k++) @(negedge clk);
    repeat (240) @(negedge clk);
    csr_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'd0) $display("FAIL drain_early: got frame_cnt %0d expected 0", rd);
    else n_pass++;
    m_status[3] = 1'b1;
    finish_frame("timeout");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_frame();
    test_irq();
    test_mode_switch();
    test_sop_err();
    test_len_err();
    test_reset_flush_timeout();
    n_checks++;
    if (valid_wo_ready !== 1'b0) $display("FAIL valid_ready: conv_valid_in seen with conv_ready_in low");
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_frame_ctrl.md
Name: conv_frame_ctrl

Overview:
Frame-level sequencer in front of the 3x3 conv filter in the avalon_filter_3x3 IP. Accepts an 8-bit grayscale Avalon-ST sink stream and forwards exactly IMAGE_WIDTH*IMAGE_HEIGHT pixels per frame into the filter. Feeds zero-valued flush pixels so the filter's line-delayed output completes, and applies host-selected display_mode only at frame boundaries. Exposes a small Avalon-MM CSR for mode, enable, status, frame count and IRQ.

Parameters:
IMAGE_WIDTH, 640, pixels per line (same value as the filter)
IMAGE_HEIGHT, 480, lines per frame
FLUSH_LEN, IMAGE_WIDTH+9, zero pixels fed after the last real pixel
EOP_TIMEOUT, 255, cycles to wait for conv_eop_out after flush

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous reset, active-low
avs_address  in  2  CSR word address
avs_write  in  1  CSR write strobe
avs_writedata  in  32  CSR write data
avs_read  in  1  CSR read strobe
avs_readdata  out  32  CSR read data, registered, 1-cycle latency
snk_data  in  8  input pixel
snk_valid  in  1  input beat valid
snk_sop  in  1  start of frame
snk_eop  in  1  end of frame
snk_ready  out  1  sink ready
conv_pxl_in  out  8  pixel to filter
conv_valid_in  out  1  pixel strobe to filter
conv_ready_in  in  1  filter ready
conv_display_mode  out  7  kernel select to filter
conv_eop_out  in  1  filter end-of-frame marker
irq  out  1  level interrupt

Behaviour:
- Reset values: snk_ready=0, conv_valid_in=0, conv_pxl_in=0, conv_display_mode=0, avs_readdata=0, irq=0. All CSRs 0. FSM=IDLE. All counters 0.
- CSR map:
  - 0 CTRL rw: [0] enable, [1] irq_en.
  - 1 MODE rw: [6:0] mode_pending.
  - 2 STATUS: [0] busy RO; [1] frame_done, sticky, W1C; [2] sop_err, sticky, W1C; [3] len_err, sticky, W1C.
  - 3 FRAME_CNT RO: [15:0], wraps 0xFFFF->0.
- irq = irq_en & frame_done.
- A write and a hardware set in the same cycle: the set wins.
- conv_display_mode = active_mode, a register. active_mode <= mode_pending on every entry to WAIT_SOP. A MODE write mid-frame does not affect the current frame.
- accept = snk_valid & snk_ready.
- FSM:
  - IDLE: snk_ready=0, busy=0. If enable=1, go to WAIT_SOP.
  - WAIT_SOP: snk_ready=conv_ready_in.
    - accept & !snk_sop: beat dropped, sop_err set.
    - accept & snk_sop: pixel forwarded, pix_cnt=1. If W*H==1 go to FLUSH, else go to STREAM.
    - enable=0 (no beat accepted): go to IDLE.
  - STREAM: snk_ready=conv_ready_in. conv_valid_in=accept, conv_pxl_in=snk_data (combinational pass-through, 0 latency). Each accept increments pix_cnt.
    - Accepting pixel W*H: go to FLUSH. If snk_eop=0 on that pixel, set len_err.
    - accept & snk_sop: sop_err set, pixel still forwarded as data.
    - accept & snk_eop before pixel W*H: len_err set, go to FLUSH with pad_cnt = W*H - pix_cnt.
  - FLUSH: snk_ready=0. conv_valid_in=1 and conv_pxl_in=0 on each cycle conv_ready_in=1.
    - First emits pad_cnt padding pixels, then FLUSH_LEN flush pixels. Then go to DRAIN.
  - DRAIN: snk_ready=0, conv_valid_in=0. Wait for conv_eop_out.
    - conv_eop_out, or timeout after EOP_TIMEOUT cycles (sets len_err): FRAME_CNT++, frame_done set.
    - Next state is WAIT_SOP if enable=1, else IDLE.
    - conv_eop_out arriving in FLUSH is latched and honoured on DRAIN entry.
- enable cleared mid-frame: the current frame completes normally, then IDLE.
- busy=1 in all states except IDLE/WAIT_SOP.
- conv_eop_out in IDLE/WAIT_SOP/STREAM is ignored.
- Counter widths: pix_cnt covers W*H; flush counter covers max(W*H, FLUSH_LEN).
- Async reset mid-frame returns everything to reset values immediately. No partial-frame state is retained.

Decomposition:
- Shared package/header conv_pkg: FSM state encodings, CSR address constants, STATUS bit indices, display_mode codes (ORIGINAL=0, GAUSS1=1, GAUSS2=2, SOBEL_X=4, SOBEL_Y=8, PREWITT_X=16, PREWITT_Y=32; any other value selects MEAN).
- One natural sub-module: conv_csr (register file, W1C logic, readdata register, irq), separate from the FSM/counters.

Test Plan:
Use IMAGE_WIDTH=8, IMAGE_HEIGHT=4, FLUSH_LEN=17; a model filter asserts conv_eop_out 3 cycles after the last flush pixel.
1. MODE=4, CTRL=1, one clean 32-pixel frame (sop on pixel 1, eop on pixel 32) -> conv_display_mode=4, exactly 32 data + 17 zero pixels on conv_valid_in, FRAME_CNT=1, STATUS=0x2, irq=0.
2. CTRL=3, same frame -> irq rises with frame_done. Writing STATUS=0x2 clears frame_done and irq next cycle.
3. MODE write of 1 during pixel 10 of frame A -> frame A keeps mode 4; frame B shows mode 1 from its first pixel.
4. Two beats without sop, then a sop frame -> sop_err=1, the two beats are never forwarded, frame proceeds with 32 pixels.
5. eop on pixel 20 -> len_err=1, 12 padding zeros + 17 flush zeros emitted, FRAME_CNT increments.
6. Assert reset_n low during FLUSH -> outputs at reset values immediately, FRAME_CNT=0. Model filter never asserts eop -> len_err set after 255 DRAIN cycles.
